// File: rtl/modport_alu.sv
`default_nettype none
// ============================================================================
// Module      : modport_alu
// Description : Registered arithmetic/logic unit. Two operands are qualified
//               by per-operand valid bits. The unit executes 11 arithmetic or
//               14 logical commands and presents a registered result with
//               carry, overflow/borrow, compare and error flags. If a
//               two-operand command arrives with only one operand valid, the
//               unit waits up to 16 enabled cycles for both operands and then
//               flags a timeout.
//
// Ports       : clk        rising-edge clock
//               RST        asynchronous active-low reset
//               CE         clock enable (low freezes every register)
//               INP_VALID  bit0 = OPA valid, bit1 = OPB valid
//               MODE       1 = arithmetic, 0 = logical
//               CMD        command code
//               OPA, OPB   operands
//               CIN        carry-in
//               RES        registered result (OP_WIDTH+1 bits)
//               COUT, OFLOW, G, L, E, ERR  registered flags
//
// Options     : ALU_MULT_EN - when defined, arithmetic CMD 9/10 (multiply)
//               are implemented with a two-cycle latency through the MUL
//               state. When undefined they are rejected with ERR.
//
// Revision    : 1.0 - initial release
// ============================================================================
module modport_alu #(
  parameter int OP_WIDTH  = 8,
  parameter int CMD_WIDTH = 4,
  parameter int SHIFT_W   = $clog2(OP_WIDTH)
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 CE,
  input  logic [1:0]           INP_VALID,
  input  logic                 MODE,
  input  logic [CMD_WIDTH-1:0] CMD,
  input  logic [OP_WIDTH-1:0]  OPA,
  input  logic [OP_WIDTH-1:0]  OPB,
  input  logic                 CIN,
  output logic [OP_WIDTH:0]    RES,
  output logic                 COUT,
  output logic                 OFLOW,
  output logic                 G,
  output logic                 L,
  output logic                 E,
  output logic                 ERR
);

  // Arithmetic is carried out one bit wider than RES so the top bit of the
  // intermediate is the borrow for subtractions.
  localparam int                c_res_w     = OP_WIDTH + 1;
  localparam int                c_cnt_w     = 4;
  localparam logic [c_cnt_w-1:0] c_wait_last = 4'd15;
  localparam logic [c_res_w:0]  c_one       = {{c_res_w{1'b0}}, 1'b1};
  localparam logic [SHIFT_W:0]  c_width_s   = (SHIFT_W+1)'(OP_WIDTH);

`ifdef ALU_MULT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1} state_t;
`endif

  state_t                 r_state, w_state_d;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_d;
  logic                   r_mode_l, w_mode_ld;
  logic [CMD_WIDTH-1:0]   r_cmd_l, w_cmd_ld;

  // Command actually being decoded: while waiting for the second operand the
  // latched MODE/CMD are used, otherwise the live inputs.
  logic                   w_mode;
  logic [CMD_WIDTH-1:0]   w_cmd;
  logic [31:0]            w_cmd_n;

  assign w_mode  = (r_state == S_WAIT) ? r_mode_l : MODE;
  assign w_cmd   = (r_state == S_WAIT) ? r_cmd_l  : CMD;
  assign w_cmd_n = 32'(w_cmd);

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  logic [c_res_w:0]       w_ax, w_bx, w_cx, w_arith;
  logic [OP_WIDTH-1:0]    w_logic;
  logic [SHIFT_W-1:0]     w_amt;
  logic [SHIFT_W:0]       w_amt_c;
  logic                   w_rot_bad;
  logic [OP_WIDTH:0]      w_res;
  logic                   w_cout, w_oflow, w_g, w_l, w_e, w_err;
`ifdef ALU_MULT_EN
  logic                   w_is_mul;
  logic [OP_WIDTH:0]      r_mul_res, w_mul_res_d;
`endif

  assign w_ax      = {2'b00, OPA};
  assign w_bx      = {2'b00, OPB};
  assign w_cx      = {{c_res_w{1'b0}}, CIN};
  assign w_amt     = OPB[SHIFT_W-1:0];
  assign w_amt_c   = c_width_s - {1'b0, w_amt};
  // Rotate amounts beyond the operand width are rejected rather than wrapped.
  assign w_rot_bad = |OPB[OP_WIDTH-1:SHIFT_W];

  always_comb begin
    w_arith = '0;
    w_logic = '0;
    w_res   = '0;
    w_cout  = 1'b0;
    w_oflow = 1'b0;
    w_g     = 1'b0;
    w_l     = 1'b0;
    w_e     = 1'b0;
    w_err   = 1'b0;
`ifdef ALU_MULT_EN
    w_is_mul = 1'b0;
`endif
    if (w_mode) begin
      case (w_cmd_n)
        0:  begin w_arith = w_ax + w_bx;         w_cout  = w_arith[OP_WIDTH]; end
        1:  begin w_arith = w_ax - w_bx;         w_oflow = w_arith[c_res_w];  end
        2:  begin w_arith = w_ax + w_bx + w_cx;  w_cout  = w_arith[OP_WIDTH]; end
        3:  begin w_arith = w_ax - w_bx - w_cx;  w_oflow = w_arith[c_res_w];  end
        4:  begin w_arith = w_ax + c_one;        w_cout  = w_arith[OP_WIDTH]; end
        5:  begin w_arith = w_ax - c_one;        w_oflow = w_arith[c_res_w];  end
        6:  begin w_arith = w_bx + c_one;        w_cout  = w_arith[OP_WIDTH]; end
        7:  begin w_arith = w_bx - c_one;        w_oflow = w_arith[c_res_w];  end
        8:  begin
          w_g = (OPA > OPB);
          w_l = (OPA < OPB);
          w_e = (OPA == OPB);
        end
`ifdef ALU_MULT_EN
        9:  begin w_arith = (w_ax + c_one) * (w_bx + c_one); w_is_mul = 1'b1; end
        10: begin w_arith = (w_ax << 1) * w_bx;             w_is_mul = 1'b1; end
`endif
        default: w_err = 1'b1;
      endcase
      w_res = w_arith[OP_WIDTH:0];
    end else begin
      case (w_cmd_n)
        0:  w_logic = OPA & OPB;
        1:  w_logic = ~(OPA & OPB);
        2:  w_logic = OPA | OPB;
        3:  w_logic = ~(OPA | OPB);
        4:  w_logic = OPA ^ OPB;
        5:  w_logic = ~(OPA ^ OPB);
        6:  w_logic = ~OPA;
        7:  w_logic = ~OPB;
        8:  w_logic = OPA >> 1;
        9:  w_logic = OPA << 1;
        10: w_logic = OPB >> 1;
        11: w_logic = OPB << 1;
        // A shift by the full width yields zero, so amount 0 rotates cleanly.
        12: if (w_rot_bad) w_err = 1'b1;
            else           w_logic = (OPA << w_amt) | (OPA >> w_amt_c);
        13: if (w_rot_bad) w_err = 1'b1;
            else           w_logic = (OPA >> w_amt) | (OPA << w_amt_c);
        default: w_err = 1'b1;
      endcase
      w_res = {1'b0, w_logic};
    end
  end

  // --------------------------------------------------------------------------
  // Operand requirements and command legality
  // --------------------------------------------------------------------------
  logic w_need_a, w_need_b, w_cmd_bad;

  always_comb begin
    w_need_a  = 1'b1;
    w_need_b  = 1'b1;
    w_cmd_bad = 1'b0;
    if (w_mode) begin
      case (w_cmd_n)
        4, 5:    w_need_b = 1'b0;
        6, 7:    w_need_a = 1'b0;
        default: ;
      endcase
`ifdef ALU_MULT_EN
      w_cmd_bad = (w_cmd_n > 32'd10);
`else
      w_cmd_bad = (w_cmd_n > 32'd8);
`endif
    end else begin
      case (w_cmd_n)
        6, 8, 9:   w_need_b = 1'b0;
        7, 10, 11: w_need_a = 1'b0;
        default:   ;
      endcase
      w_cmd_bad = (w_cmd_n > 32'd13);
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM: next state and next outputs
  // --------------------------------------------------------------------------
  logic              w_publish, w_fail;
  logic [OP_WIDTH:0] w_res_d;
  logic              w_cout_d, w_oflow_d, w_g_d, w_l_d, w_e_d, w_err_d;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_mode_ld = r_mode_l;
    w_cmd_ld  = r_cmd_l;
    w_publish = 1'b0;
    w_fail    = 1'b0;
`ifdef ALU_MULT_EN
    w_mul_res_d = r_mul_res;
`endif
    case (r_state)
      S_IDLE: begin
        if (INP_VALID == 2'b00 || w_cmd_bad) begin
          w_fail = 1'b1;
        end else if ((w_need_a && !INP_VALID[0]) || (w_need_b && !INP_VALID[1])) begin
          // Only a two-operand command may wait for its missing operand; a
          // single-operand command presented with the wrong operand is an error.
          if (w_need_a && w_need_b) begin
            w_state_d = S_WAIT;
            w_cnt_d   = '0;
            w_mode_ld = MODE;
            w_cmd_ld  = CMD;
          end else begin
            w_fail = 1'b1;
          end
        end else begin
          w_publish = 1'b1;
`ifdef ALU_MULT_EN
          if (w_is_mul) begin
            w_publish   = 1'b0;
            w_mul_res_d = w_res;
            w_state_d   = S_MUL;
          end
`endif
        end
      end
      S_WAIT: begin
        if (INP_VALID == 2'b11) begin
          w_state_d = S_IDLE;
          w_publish = 1'b1;
`ifdef ALU_MULT_EN
          if (w_is_mul) begin
            w_publish   = 1'b0;
            w_mul_res_d = w_res;
            w_state_d   = S_MUL;
          end
`endif
        end else if (r_cnt == c_wait_last) begin
          w_fail    = 1'b1;
          w_state_d = S_IDLE;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
`ifdef ALU_MULT_EN
      S_MUL: begin
        w_state_d = S_IDLE;
      end
`endif
      default: w_state_d = S_IDLE;
    endcase

    // Outputs hold unless a command completes; a completion clears every
    // flag the command does not itself set.
    w_res_d   = RES;
    w_cout_d  = COUT;
    w_oflow_d = OFLOW;
    w_g_d     = G;
    w_l_d     = L;
    w_e_d     = E;
    w_err_d   = ERR;
    if (w_publish) begin
      w_res_d   = w_res;
      w_cout_d  = w_cout;
      w_oflow_d = w_oflow;
      w_g_d     = w_g;
      w_l_d     = w_l;
      w_e_d     = w_e;
      w_err_d   = w_err;
    end else if (w_fail) begin
      w_res_d   = '0;
      w_cout_d  = 1'b0;
      w_oflow_d = 1'b0;
      w_g_d     = 1'b0;
      w_l_d     = 1'b0;
      w_e_d     = 1'b0;
      w_err_d   = 1'b1;
    end
`ifdef ALU_MULT_EN
    else if (r_state == S_MUL) begin
      w_res_d   = r_mul_res;
      w_cout_d  = 1'b0;
      w_oflow_d = 1'b0;
      w_g_d     = 1'b0;
      w_l_d     = 1'b0;
      w_e_d     = 1'b0;
      w_err_d   = 1'b0;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_mode_l <= 1'b0;
      r_cmd_l  <= '0;
      RES      <= '0;
      COUT     <= 1'b0;
      OFLOW    <= 1'b0;
      G        <= 1'b0;
      L        <= 1'b0;
      E        <= 1'b0;
      ERR      <= 1'b0;
`ifdef ALU_MULT_EN
      r_mul_res <= '0;
`endif
    end else if (CE) begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_mode_l <= w_mode_ld;
      r_cmd_l  <= w_cmd_ld;
      RES      <= w_res_d;
      COUT     <= w_cout_d;
      OFLOW    <= w_oflow_d;
      G        <= w_g_d;
      L        <= w_l_d;
      E        <= w_e_d;
      ERR      <= w_err_d;
`ifdef ALU_MULT_EN
      r_mul_res <= w_mul_res_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modport_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_modport_alu
// Description : Self-checking bench for modport_alu. Single-cycle commands
//               are applied from a vector table; waiting, timeout, clock
//               enable, reset and multiply behaviour use short hand-written
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_alu;

  logic       clk = 1'b0;
  logic       RST;
  logic       CE;
  logic [1:0] INP_VALID;
  logic       MODE;
  logic [3:0] CMD;
  logic [7:0] OPA, OPB;
  logic       CIN;
  logic [8:0] RES;
  logic       COUT, OFLOW, G, L, E, ERR;

  always #5 clk = ~clk;

  modport_alu #(.OP_WIDTH(8), .CMD_WIDTH(4)) dut (
    .clk(clk), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
    .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES),
    .COUT(COUT), .OFLOW(OFLOW), .G(G), .L(L), .E(E), .ERR(ERR)
  );

  int total = 0;
  int bad   = 0;

  // flg = {COUT, OFLOW, G, L, E, ERR}
  typedef struct {
    logic       mode;
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [1:0] iv;
    logic [8:0] res;
    logic [5:0] flg;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic m, input logic [3:0] c,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic ci, input logic [1:0] iv,
                              input logic [8:0] r, input logic [5:0] f);
    vec_t v;
    v.mode = m; v.cmd = c; v.a = a; v.b = b; v.cin = ci; v.iv = iv;
    v.res = r;  v.flg = f;
    return v;
  endfunction

  task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic [1:0] iv);
    MODE = m; CMD = c; OPA = a; OPB = b; CIN = ci; INP_VALID = iv;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [8:0] er, input logic [5:0] ef);
    logic [5:0] gf;
    gf = {COUT, OFLOW, G, L, E, ERR};
    total++;
    if (RES !== er || gf !== ef) begin
      bad++;
      $display("FAIL %s: got RES=%h flags=%b, expected RES=%h flags=%b",
               name, RES, gf, er, ef);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //                  mode  cmd    a       b      cin   iv      res      {co,of,g,l,e,er}
    vecs[0]  = mk(1'b1, 4'd0,  8'd200, 8'd100, 1'b0, 2'b11, 9'h12C, 6'b100000);
    vecs[1]  = mk(1'b1, 4'd1,  8'd5,   8'd10,  1'b0, 2'b11, 9'h1FB, 6'b010000);
    vecs[2]  = mk(1'b1, 4'd8,  8'd7,   8'd7,   1'b0, 2'b11, 9'h000, 6'b000010);
    vecs[3]  = mk(1'b1, 4'd8,  8'd9,   8'd7,   1'b0, 2'b11, 9'h000, 6'b001000);
    vecs[4]  = mk(1'b1, 4'd8,  8'd2,   8'd7,   1'b0, 2'b11, 9'h000, 6'b000100);
    vecs[5]  = mk(1'b1, 4'd2,  8'd255, 8'd255, 1'b1, 2'b11, 9'h1FF, 6'b100000);
    vecs[6]  = mk(1'b1, 4'd3,  8'd3,   8'd3,   1'b1, 2'b11, 9'h1FF, 6'b010000);
    vecs[7]  = mk(1'b1, 4'd3,  8'd5,   8'd3,   1'b1, 2'b11, 9'h001, 6'b000000);
    vecs[8]  = mk(1'b1, 4'd5,  8'd0,   8'h55,  1'b0, 2'b01, 9'h1FF, 6'b010000);
    vecs[9]  = mk(1'b1, 4'd6,  8'h12,  8'd255, 1'b0, 2'b10, 9'h100, 6'b100000);
    vecs[10] = mk(1'b1, 4'd7,  8'h12,  8'd0,   1'b0, 2'b10, 9'h1FF, 6'b010000);
    vecs[11] = mk(1'b0, 4'd12, 8'h81,  8'h01,  1'b0, 2'b11, 9'h003, 6'b000000);
    vecs[12] = mk(1'b0, 4'd12, 8'h81,  8'h11,  1'b0, 2'b11, 9'h000, 6'b000001);
    vecs[13] = mk(1'b0, 4'd13, 8'h81,  8'h01,  1'b0, 2'b11, 9'h0C0, 6'b000000);
    vecs[14] = mk(1'b0, 4'd1,  8'hF0,  8'h3C,  1'b0, 2'b11, 9'h0CF, 6'b000000);
    vecs[15] = mk(1'b0, 4'd5,  8'hF0,  8'h3C,  1'b0, 2'b11, 9'h033, 6'b000000);
    vecs[16] = mk(1'b0, 4'd9,  8'h81,  8'h00,  1'b0, 2'b01, 9'h002, 6'b000000);
    vecs[17] = mk(1'b0, 4'd10, 8'h00,  8'h81,  1'b0, 2'b10, 9'h040, 6'b000000);
    vecs[18] = mk(1'b0, 4'd14, 8'h12,  8'h34,  1'b0, 2'b11, 9'h000, 6'b000001);
    vecs[19] = mk(1'b1, 4'd11, 8'h12,  8'h34,  1'b0, 2'b11, 9'h000, 6'b000001);
    vecs[20] = mk(1'b1, 4'd0,  8'h12,  8'h34,  1'b0, 2'b00, 9'h000, 6'b000001);
    vecs[21] = mk(1'b0, 4'd6,  8'h0F,  8'h00,  1'b0, 2'b01, 9'h0F0, 6'b000000);
    vecs[22] = mk(1'b1, 4'd4,  8'hFF,  8'h00,  1'b0, 2'b01, 9'h100, 6'b100000);
    vecs[23] = mk(1'b0, 4'd13, 8'h5A,  8'h00,  1'b0, 2'b11, 9'h05A, 6'b000000);

    // Reset
    RST = 1'b1;
    CE  = 1'b1;
    drive(1'b1, 4'd0, 8'd0, 8'd0, 1'b0, 2'b00);
    #3 RST = 1'b0;
    #1 check("reset_state", 9'h000, 6'b000000);
    tick;
    tick;
    RST = 1'b1;
    tick;
    check("inp_valid_00", 9'h000, 6'b000001);

    // Single-cycle command table
    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].mode, vecs[i].cmd, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].iv);
      tick;
      check($sformatf("vec%0d", i), vecs[i].res, vecs[i].flg);
    end

    // Clock enable freezes outputs
    drive(1'b1, 4'd0, 8'd1, 8'd2, 1'b0, 2'b11);
    tick;
    check("ce_pre", 9'h003, 6'b000000);
    CE = 1'b0;
    drive(1'b1, 4'd0, 8'd10, 8'd20, 1'b0, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("ce_frozen%0d", i), 9'h003, 6'b000000);
    end
    CE = 1'b1;
    tick;
    check("ce_resume", 9'd30, 6'b000000);

    // Timeout after 16 waiting cycles
    drive(1'b1, 4'd4, 8'd4, 8'd0, 1'b0, 2'b01);
    tick;
    check("pre_wait", 9'd5, 6'b000000);
    drive(1'b1, 4'd0, 8'd1, 8'd2, 1'b0, 2'b01);
    tick;
    repeat (15) tick;
    check("wait_hold_15", 9'd5, 6'b000000);
    tick;
    check("timeout_16", 9'h000, 6'b000001);

    // Second operand arrives on the 5th waiting cycle; MODE/CMD stay latched
    drive(1'b1, 4'd0, 8'd1, 8'd2, 1'b0, 2'b01);
    tick;
    repeat (4) tick;
    check("wait_hold_4", 9'h000, 6'b000001);
    drive(1'b0, 4'd2, 8'd200, 8'd100, 1'b0, 2'b11);
    tick;
    check("wait_complete", 9'h12C, 6'b100000);

    // Disabled cycles do not count toward the timeout
    drive(1'b1, 4'd1, 8'd1, 8'd2, 1'b0, 2'b01);
    tick;
    repeat (10) tick;
    CE = 1'b0;
    repeat (10) tick;
    CE = 1'b1;
    repeat (5) tick;
    check("wait_ce_hold", 9'h12C, 6'b100000);
    tick;
    check("timeout_ce", 9'h000, 6'b000001);

    // Asynchronous reset in the middle of a wait
    drive(1'b1, 4'd0, 8'd7, 8'd8, 1'b0, 2'b11);
    tick;
    check("pre_reset", 9'h00F, 6'b000000);
    drive(1'b1, 4'd0, 8'd1, 8'd2, 1'b0, 2'b10);
    tick;
    #2 RST = 1'b0;
    #1 check("reset_mid_wait", 9'h000, 6'b000000);
    @(negedge clk);
    RST = 1'b1;
    drive(1'b1, 4'd4, 8'd9, 8'd0, 1'b0, 2'b01);
    tick;
    check("after_reset", 9'h00A, 6'b000000);

`ifdef ALU_MULT_EN
    // Multiply: two-cycle latency, inputs during MUL ignored
    drive(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
    tick;
    check("mul_pending", 9'h00A, 6'b000000);
    drive(1'b1, 4'd0, 8'd50, 8'd50, 1'b0, 2'b11);
    tick;
    check("mul_result", 9'd20, 6'b000000);
    tick;
    check("after_mul", 9'd100, 6'b000000);
    drive(1'b1, 4'd10, 8'd3, 8'd4, 1'b0, 2'b11);
    tick;
    CE = 1'b0;
    repeat (3) tick;
    check("mul_ce_frozen", 9'd100, 6'b000000);
    CE = 1'b1;
    tick;
    check("mul_shift_result", 9'd24, 6'b000000);
`else
    // Without the multiplier, multiply commands are rejected
    drive(1'b1, 4'd9, 8'd3, 8'd4, 1'b0, 2'b11);
    tick;
    check("mul9_disabled", 9'h000, 6'b000001);
    drive(1'b1, 4'd0, 8'd3, 8'd4, 1'b0, 2'b11);
    tick;
    check("between_mul", 9'd7, 6'b000000);
    drive(1'b1, 4'd10, 8'd3, 8'd4, 1'b0, 2'b11);
    tick;
    check("mul10_disabled", 9'h000, 6'b000001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/modport_alu.md
# modport_alu

Registered, parameterised arithmetic/logic unit for the ALU verification environment. It accepts two operands with per-operand valid qualifiers, executes one of 11 arithmetic or 14 logical commands, and presents a registered result with carry, overflow, compare and error flags. A 16-cycle operand-wait timeout flags commands whose second operand never arrives.

## Interface
- OP_WIDTH, 8: operand width.
- CMD_WIDTH, 4: command width.
- SHIFT_W, $clog2(OP_WIDTH) (3): rotate-amount width.

- clk  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- CE  in  1  clock enable; low freezes all state and outputs.
- INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
- MODE  in  1  1 = arithmetic, 0 = logical.
- CMD  in  CMD_WIDTH  command code.
- OPA, OPB  in  OP_WIDTH  operands.
- CIN  in  1  carry-in.
- RES  out  OP_WIDTH+1  result.
- COUT, OFLOW, G, L, E, ERR  out  1  carry, overflow/borrow, greater, less, equal, error.

## Operation
- Arithmetic (MODE=1): 0 A+B; 1 A−B; 2 A+B+CIN; 3 A−B−CIN; 4 A+1; 5 A−1; 6 B+1; 7 B−1; 8 compare (RES=0; G=A>B, L=A<B, E=A==B); 9 (A+1)*(B+1); 10 (A<<1)*B. CMD>10 → ERR.
- Logical (MODE=0): 0 AND; 1 NAND; 2 OR; 3 NOR; 4 XOR; 5 XNOR; 6 ~A; 7 ~B; 8 A>>1; 9 A<<1; 10 B>>1; 11 B<<1; 12 rotate-left A by OPB[SHIFT_W-1:0]; 13 rotate-right A likewise. CMD>13 → ERR. Logical RES[OP_WIDTH]=0.
- ROL/ROR with any OPB bit above SHIFT_W-1 set → ERR, RES=0.
- All arithmetic unsigned; RES holds the OP_WIDTH+1-bit sum/difference (modulo 2^(OP_WIDTH+1)); multiply RES truncated to low OP_WIDTH+1 bits.
- COUT=RES[OP_WIDTH] for CMD 0,2,4,6. OFLOW=1 on borrow for CMD 1,3,5,7 (result below zero).
- Every new result clears flags not set by that command.
- Operand needs: CMD 4,5 and logical 6,8,9 need OPA only; CMD 6,7 and logical 7,10,11 need OPB only; all others need both.
- INP_VALID=00 → ERR, RES=0, next cycle.
- FSM: IDLE, WAIT, MUL.
  - IDLE: required operands valid → compute; multiply → MUL; else result registered.
  - IDLE, two-operand command with only one valid bit → WAIT; MODE/CMD latched; cycle counter cleared.
  - WAIT: INP_VALID=11 → compute with operands of that cycle, → IDLE. Otherwise counter increments; after the 16th waiting cycle → ERR=1, RES=0, → IDLE.
  - MUL: result published, → IDLE.
- CE low: no state, counter or output changes.

## Timing
- Reset (RST=0, async): RES=0, all flags 0, FSM IDLE, counter 0. Reset asserted mid-WAIT or mid-MUL aborts the operation with no output.
- Non-multiply latency: inputs sampled at edge N, outputs valid after edge N+1.
- Multiply latency: outputs valid after edge N+2; new inputs during MUL ignored.
- Timeout: ERR asserted after the 16th CE-qualified cycle following the partial-valid cycle.
- Outputs hold until the next completed command.

## Configuration
- ALU_MULT_EN defined: arithmetic CMD 9 and 10 implemented as above, MUL state present.
- Undefined: CMD 9/10 treated as invalid → ERR next cycle; no multiplier, no MUL state.

## Test plan
- MODE=1, CMD=0, A=200, B=100, INP_VALID=11 -> RES=300 (9'h12C), COUT=1, one-cycle latency.
- MODE=1, CMD=1, A=5, B=10 -> RES=9'h1FB, OFLOW=1; CMD=8, A=B=7 -> E=1, G=L=0.
- MODE=0, CMD=12, A=8'h81, B=8'h01 -> RES=8'h03; same with B=8'h11 -> ERR=1.
- MODE=1, CMD=0, INP_VALID=01 held 16 cycles -> ERR=1; repeat with INP_VALID=11 on cycle 5 -> correct sum, ERR=0.
- ALU_MULT_EN: MODE=1, CMD=9, A=3, B=4 -> RES=20 after two cycles; CE low for 3 cycles -> outputs frozen.
- RST=0 mid-WAIT -> all outputs 0 immediately; INP_VALID=00 -> ERR=1.
